mem_bus_arbiter: RTL and testbench

- Shares the single memory bus (RAM, ROM, GPIO registers at 254/255) between two requesters: master 0 is the CPU datapath, master 1 is a DMA/boot-loader engine.
- Round-robin arbitration with a req/gnt/done handshake; each transaction takes a fixed number of bus cycles.
- Sits between the masters and the existing RAM/ROM/peripheral chip-select decode, which keeps operating on mem_address unchanged.

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/arb_rr2.sv | 26 ++
 rtl/mem_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory bus arbiter and the bus address decode.
package mem_arb_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam logic [31:0] GPIO_DIR_ADDRESS = 32'd254;
  localparam logic [31:0] GPIO_RW_ADDRESS  = 32'd255;

  // One latched bus command: everything a master presents with its request.
  typedef struct packed {
    logic [31:0] addr;
    logic [63:0] wdata;
    logic        we;
    logic [1:0]  size;
  } bus_req_t;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick with an optional per-master lock override.
module arb_rr2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  input  logic [1:0] i_lock,
  output logic       o_winner,
  output logic       o_valid
);

  always_comb begin
    o_valid  = |i_req;
    o_winner = M_CPU;
    if (i_lock[0] && i_req[0]) begin
      o_winner = M_CPU;
    end else if (i_lock[1] && i_req[1]) begin
      o_winner = M_DMA;
    end else if (&i_req) begin
      o_winner = ~i_last_grant;
    end else if (i_req[1]) begin
      o_winner = M_DMA;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the memory bus between the CPU (master 0) and the DMA engine (master 1).
// Optional feature macro: MEM_ARB_LOCK_EN adds m0_lock/m1_lock for back-to-back ownership.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ACCESS_CYCLES = 2,
  parameter int unsigned RR_INIT       = 0,
  parameter int unsigned CNT_W         = 4
) (
  input  logic        clock,
  input  logic        reset,
`ifdef MEM_ARB_LOCK_EN
  input  logic        m0_lock,
  input  logic        m1_lock,
`endif
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [63:0] m0_wdata,
  input  logic [63:0] m1_wdata,
  input  logic        m0_we,
  input  logic        m1_we,
  input  logic [1:0]  m0_size,
  input  logic [1:0]  m1_size,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_done,
  output logic        m1_done,
  output logic [63:0] m0_rdata,
  output logic [63:0] m1_rdata,
  output logic [31:0] mem_address,
  output logic [63:0] mem_wdata,
  output logic        mem_write_en,
  output logic        mem_read,
  output logic [1:0]  mem_size,
  input  logic [63:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(ACCESS_CYCLES - 1);
  localparam logic             L_RR_INIT = (RR_INIT != 0);

  logic [1:0]       r_state;
  logic             r_owner;
  logic             r_last_grant;
  logic [CNT_W-1:0] r_cnt;
  bus_req_t         r_bus;
  logic [63:0]      r_m0_rdata;
  logic [63:0]      r_m1_rdata;

  logic [1:0] w_req;
  logic [1:0] w_lock;
  logic       w_winner;
  logic       w_valid;
  logic       w_access;
  logic       w_busy;
  logic       w_last_beat;
  bus_req_t   w_m0_cmd;
  bus_req_t   w_m1_cmd;

  assign w_req       = {m1_req, m0_req};
  assign w_access    = (r_state == ACCESS);
  assign w_busy      = (r_state == ACCESS) || (r_state == DONE);
  assign w_last_beat = w_access && (r_cnt == '0);

  assign w_m0_cmd = '{addr: m0_addr, wdata: m0_wdata, we: m0_we, size: m0_size};
  assign w_m1_cmd = '{addr: m1_addr, wdata: m1_wdata, we: m1_we, size: m1_size};

`ifdef MEM_ARB_LOCK_EN
  logic r_lock_hold;
  logic w_owner_lock;

  // Lock is sampled in the DONE cycle; r_last_grant already names the owner by the next IDLE.
  assign w_owner_lock = (r_owner == M_DMA) ? (m1_lock && m1_req) : (m0_lock && m0_req);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lock_hold <= 1'b0;
    end else if (r_state == DONE) begin
      r_lock_hold <= w_owner_lock;
    end else if ((r_state == IDLE) && w_valid) begin
      r_lock_hold <= 1'b0;
    end
  end

  assign w_lock = !r_lock_hold ? 2'b00 : ((r_last_grant == M_DMA) ? 2'b10 : 2'b01);
`else
  assign w_lock = 2'b00;
`endif

  arb_rr2 u_arb (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .i_lock       (w_lock),
    .o_winner     (w_winner),
    .o_valid      (w_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_owner      <= M_CPU;
      r_last_grant <= ~L_RR_INIT;
      r_cnt        <= '0;
      r_bus        <= '0;
      r_m0_rdata   <= '0;
      r_m1_rdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_owner <= w_winner;
            r_bus   <= (w_winner == M_DMA) ? w_m1_cmd : w_m0_cmd;
            r_cnt   <= CNT_LOAD;
            r_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (r_cnt == '0) begin
            if (!r_bus.we) begin
              if (r_owner == M_DMA) begin
                r_m1_rdata <= mem_rdata;
              end else begin
                r_m0_rdata <= mem_rdata;
              end
            end
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        DONE: begin
          r_last_grant <= r_owner;
          r_bus        <= '0;
          r_state      <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The bus is only driven during ACCESS, so nothing can strobe outside a grant.
  always_comb begin
    m0_gnt       = w_busy && (r_owner == M_CPU);
    m1_gnt       = w_busy && (r_owner == M_DMA);
    m0_done      = (r_state == DONE) && (r_owner == M_CPU);
    m1_done      = (r_state == DONE) && (r_owner == M_DMA);
    mem_address  = '0;
    mem_wdata    = '0;
    mem_size     = '0;
    mem_read     = 1'b0;
    mem_write_en = 1'b0;
    if (w_access) begin
      mem_address  = r_bus.addr;
      mem_wdata    = r_bus.wdata;
      mem_size     = r_bus.size;
      mem_read     = ~r_bus.we;
      mem_write_en = r_bus.we && w_last_beat;
    end
  end

  assign m0_rdata = r_m0_rdata;
  assign m1_rdata = r_m1_rdata;

  a_wr_needs_gnt: assert property (@(posedge clock) disable iff (!reset)
    mem_write_en |-> (m0_gnt || m1_gnt));
  a_one_owner: assert property (@(posedge clock) disable iff (!reset)
    !(m0_gnt && m1_gnt));
  a_one_strobe: assert property (@(posedge clock) disable iff (!reset)
    mem_write_en |=> !mem_write_en);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter with a small RAM + GPIO model on the shared bus.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AC = 2;

  typedef struct {
    logic        master;
    logic        we;
    logic [63:0] rdata;
  } exp_t;

  logic        clock;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic [63:0] m0_wdata, m1_wdata;
  logic        m0_we, m1_we;
  logic [1:0]  m0_size, m1_size;
`ifdef MEM_ARB_LOCK_EN
  logic        m0_lock, m1_lock;
`endif
  logic        m0_gnt, m1_gnt, m0_done, m1_done;
  logic [63:0] m0_rdata, m1_rdata;
  logic [31:0] mem_address;
  logic [63:0] mem_wdata;
  logic        mem_write_en, mem_read;
  logic [1:0]  mem_size;
  logic [63:0] mem_rdata;

  exp_t sb_q[$];
  int   n_pass;
  int   n_total;
  int   n_strobes;
  int   n_bad_strobes;
  logic [31:0] last_wr_addr;

  bit [63:0] ram [0:255];
  bit [7:0]  p_out;
  bit [7:0]  p_dir;

  mem_bus_arbiter #(
    .ACCESS_CYCLES (AC),
    .RR_INIT       (0),
    .CNT_W         (4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
`ifdef MEM_ARB_LOCK_EN
    .m0_lock      (m0_lock),
    .m1_lock      (m1_lock),
`endif
    .m0_req       (m0_req),
    .m1_req       (m1_req),
    .m0_addr      (m0_addr),
    .m1_addr      (m1_addr),
    .m0_wdata     (m0_wdata),
    .m1_wdata     (m1_wdata),
    .m0_we        (m0_we),
    .m1_we        (m1_we),
    .m0_size      (m0_size),
    .m1_size      (m1_size),
    .m0_gnt       (m0_gnt),
    .m1_gnt       (m1_gnt),
    .m0_done      (m0_done),
    .m1_done      (m1_done),
    .m0_rdata     (m0_rdata),
    .m1_rdata     (m1_rdata),
    .mem_address  (mem_address),
    .mem_wdata    (mem_wdata),
    .mem_write_en (mem_write_en),
    .mem_read     (mem_read),
    .mem_size     (mem_size),
    .mem_rdata    (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_write_en) begin
      if (mem_address == GPIO_RW_ADDRESS) p_out <= mem_wdata[7:0];
      else if (mem_address == GPIO_DIR_ADDRESS) p_dir <= mem_wdata[7:0];
      else ram[mem_address[7:0]] <= mem_wdata;
    end
  end

  assign mem_rdata = !mem_read ? 64'h0 :
                     (mem_address == GPIO_RW_ADDRESS)  ? {56'h0, p_out} :
                     (mem_address == GPIO_DIR_ADDRESS) ? {56'h0, p_dir} :
                     ram[mem_address[7:0]];

  always @(negedge clock) begin
    if (mem_write_en) begin
      n_strobes    = n_strobes + 1;
      last_wr_addr = mem_address;
      if (!(m0_gnt || m1_gnt)) n_bad_strobes = n_bad_strobes + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_m(input logic m, input logic [31:0] a, input logic [63:0] wd,
                         input logic we, input logic req);
    if (m == M_DMA) begin
      m1_addr = a; m1_wdata = wd; m1_we = we; m1_size = 2'b11; m1_req = req;
    end else begin
      m0_addr = a; m0_wdata = wd; m0_we = we; m0_size = 2'b11; m0_req = req;
    end
  endtask

  task automatic push_exp(input logic m, input logic we, input logic [63:0] rd);
    exp_t e;
    e.master = m;
    e.we     = we;
    e.rdata  = rd;
    sb_q.push_back(e);
  endtask

  // Pops one entry per done pulse; returns one cycle after the last DONE (arbiter back in IDLE).
  task automatic wait_sb(input int target, input int budget, input string tag);
    int   i = 0;
    exp_t e;
    logic [63:0] rd;
    while (sb_q.size() > target && i < budget) begin
      @(negedge clock);
      i++;
      if (m0_done || m1_done) begin
        n_total++;
        e  = sb_q.pop_front();
        rd = m1_done ? m1_rdata : m0_rdata;
        if ((m0_done && m1_done) || (m1_done !== e.master) || (!e.we && rd !== e.rdata))
          $display("FAIL %s_sb: got done m0=%0d m1=%0d rdata %h, required master %0d rdata %h",
                   tag, m0_done, m1_done, rd, e.master, e.rdata);
        else n_pass++;
      end
    end
    @(posedge clock);
    #1;
    n_total++;
    if (sb_q.size() > target) begin
      $display("FAIL %s_timeout: %0d entries pending, required %0d", tag, sb_q.size(), target);
      sb_q.delete();
    end else if ({m0_gnt, m1_gnt, m0_done, m1_done} !== 4'b0000) begin
      $display("FAIL %s_idle: gnt/done %b, required 0000", tag,
               {m0_gnt, m1_gnt, m0_done, m1_done});
    end else n_pass++;
  endtask

  task automatic run_txn(input logic m, input logic [31:0] a, input logic [63:0] wd,
                         input logic we, input logic [63:0] rd, input string tag);
    push_exp(m, we, rd);
    drive_m(m, a, wd, we, 1'b1);
    wait_sb(0, 40, tag);
    drive_m(m, a, wd, we, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_total++;
    if ({m0_gnt, m1_gnt, m0_done, m1_done, mem_write_en, mem_read} !== 6'b0)
      $display("FAIL reset_ctrl: %b, required 000000",
               {m0_gnt, m1_gnt, m0_done, m1_done, mem_write_en, mem_read});
    else n_pass++;
    n_total++;
    if ({mem_address, mem_wdata, mem_size, m0_rdata, m1_rdata} !== '0)
      $display("FAIL reset_bus: addr %h wdata %h size %b, required 0", mem_address, mem_wdata,
               mem_size);
    else n_pass++;
    reset = 1'b1;
    repeat (3) tick();
    n_total++;
    if ({m0_gnt, m1_gnt} !== 2'b00) $display("FAIL idle_no_req: gnt %b, required 00",
                                              {m0_gnt, m1_gnt});
    else n_pass++;
  endtask

  task automatic test_single_read();
    run_txn(M_DMA, 32'h10, 64'hDEAD_BEEF, 1'b1, 64'h0, "preload0");
    run_txn(M_DMA, 32'h11, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0, "preload1");
    drive_m(M_CPU, 32'h10, 64'h0, 1'b0, 1'b1);
    tick();
    n_total++;
    if ({m0_gnt, m1_gnt, mem_read, mem_write_en, mem_address, mem_size} !==
        {4'b1010, 32'h10, 2'b11})
      $display("FAIL sr_edge0: gnt %b%b rd %b we %b addr %h size %b, required 1010 10 11",
               m0_gnt, m1_gnt, mem_read, mem_write_en, mem_address, mem_size);
    else n_pass++;
    tick();
    n_total++;
    if ({mem_read, m0_done} !== 2'b10)
      $display("FAIL sr_edge1: read %b done %b, required 1 0", mem_read, m0_done);
    else n_pass++;
    tick();
    n_total++;
    if ({mem_read, m0_done, m0_gnt} !== 3'b011)
      $display("FAIL sr_edge2: read %b done %b gnt %b, required 0 1 1", mem_read, m0_done, m0_gnt);
    else n_pass++;
    n_total++;
    if (m0_rdata !== 64'hDEAD_BEEF)
      $display("FAIL sr_rdata: %h, required 00000000deadbeef", m0_rdata);
    else n_pass++;
    m0_req = 1'b0;
    tick();
    n_total++;
    if ({m0_gnt, m1_gnt, m0_done, mem_read} !== 4'b0)
      $display("FAIL sr_release: %b, required 0000", {m0_gnt, m1_gnt, m0_done, mem_read});
    else n_pass++;
  endtask

  task automatic test_gpio_write();
    int s0;
    s0 = n_strobes;
    push_exp(M_DMA, 1'b1, 64'h0);
    drive_m(M_DMA, GPIO_RW_ADDRESS, 64'h55, 1'b1, 1'b1);
    tick();
    n_total++;
    if ({m0_gnt, m1_gnt} !== 2'b01) $display("FAIL gpio_gnt: %b, required 01", {m0_gnt, m1_gnt});
    else n_pass++;
    m1_addr  = 32'h40;
    m1_wdata = 64'hAA;
    wait_sb(0, 40, "gpio");
    m1_req = 1'b0;
    n_total++;
    if (n_strobes - s0 != 1) $display("FAIL gpio_strobes: %0d, required 1", n_strobes - s0);
    else n_pass++;
    n_total++;
    if (last_wr_addr !== GPIO_RW_ADDRESS)
      $display("FAIL gpio_addr: %h, required 000000ff", last_wr_addr);
    else n_pass++;
    n_total++;
    if (p_out !== 8'h55) $display("FAIL gpio_pout: %h, required 55", p_out);
    else n_pass++;
    n_total++;
    if (n_bad_strobes != 0 || ram[8'h40] != 64'h0)
      $display("FAIL gpio_stray: bad strobes %0d ram40 %h, required 0 0", n_bad_strobes,
               ram[8'h40]);
    else n_pass++;
  endtask

  task automatic test_alternation();
    pulse_reset();
    drive_m(M_CPU, 32'h10, 64'h0, 1'b0, 1'b1);
    drive_m(M_DMA, 32'h11, 64'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      push_exp(M_CPU, 1'b0, 64'hDEAD_BEEF);
      push_exp(M_DMA, 1'b0, 64'h0123_4567_89AB_CDEF);
    end
    wait_sb(0, 100, "alt");
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    int s0;
    s0 = n_strobes;
    drive_m(M_CPU, 32'h30, 64'hCAFE, 1'b1, 1'b1);
    @(posedge clock);
    #3;
    n_total++;
    if (m0_gnt !== 1'b1) $display("FAIL rm_gnt: %b, required 1", m0_gnt);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if ({m0_gnt, m1_gnt, m0_done, m1_done, mem_write_en, mem_read, mem_address, mem_wdata,
         m0_rdata, m1_rdata} !== '0)
      $display("FAIL rm_outputs: gnt %b%b we %b addr %h wdata %h, required all 0", m0_gnt, m1_gnt,
               mem_write_en, mem_address, mem_wdata);
    else n_pass++;
    m0_req = 1'b0;
    repeat (3) begin
      tick();
      n_total++;
      if ({m0_done, m1_done, mem_write_en} !== 3'b000)
        $display("FAIL rm_quiet: done %b%b we %b, required 000", m0_done, m1_done, mem_write_en);
      else n_pass++;
    end
    n_total++;
    if (n_strobes != s0 || ram[8'h30] != 64'h0)
      $display("FAIL rm_nowrite: strobes %0d ram30 %h, required %0d 0", n_strobes, ram[8'h30], s0);
    else n_pass++;
    reset = 1'b1;
    drive_m(M_CPU, 32'h10, 64'h0, 1'b0, 1'b1);
    drive_m(M_DMA, 32'h11, 64'h0, 1'b0, 1'b1);
    push_exp(M_CPU, 1'b0, 64'hDEAD_BEEF);
    push_exp(M_DMA, 1'b0, 64'h0123_4567_89AB_CDEF);
    tick();
    n_total++;
    if ({m0_gnt, m1_gnt} !== 2'b10) $display("FAIL rm_first_grant: %b, required 10",
                                              {m0_gnt, m1_gnt});
    else n_pass++;
    wait_sb(0, 40, "rm_after");
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic test_req_drop();
    push_exp(M_CPU, 1'b0, 64'h0123_4567_89AB_CDEF);
    drive_m(M_CPU, 32'h11, 64'h0, 1'b0, 1'b1);
    tick();
    n_total++;
    if (m0_gnt !== 1'b1) $display("FAIL drop_gnt: %b, required 1", m0_gnt);
    else n_pass++;
    m0_req = 1'b0;
    wait_sb(0, 40, "drop");
    tick();
    n_total++;
    if ({m0_gnt, m1_gnt} !== 2'b00) $display("FAIL drop_no_regrant: %b, required 00",
                                              {m0_gnt, m1_gnt});
    else n_pass++;
    // m0 keeps its request: regranted while m1 is idle, loses to m1 once m1 asks.
    push_exp(M_CPU, 1'b0, 64'hDEAD_BEEF);
    push_exp(M_CPU, 1'b0, 64'hDEAD_BEEF);
    drive_m(M_CPU, 32'h10, 64'h0, 1'b0, 1'b1);
    wait_sb(0, 40, "hold_m0");
    drive_m(M_DMA, 32'h11, 64'h0, 1'b0, 1'b1);
    push_exp(M_DMA, 1'b0, 64'h0123_4567_89AB_CDEF);
    push_exp(M_CPU, 1'b0, 64'hDEAD_BEEF);
    wait_sb(1, 40, "hold_m1");
    m1_req = 1'b0;
    wait_sb(0, 40, "hold_back");
    m0_req = 1'b0;
  endtask

`ifdef MEM_ARB_LOCK_EN
  task automatic test_lock();
    pulse_reset();
    m0_lock = 1'b1;
    drive_m(M_CPU, 32'h10, 64'h0, 1'b0, 1'b1);
    drive_m(M_DMA, 32'h11, 64'h0, 1'b0, 1'b1);
    repeat (3) push_exp(M_CPU, 1'b0, 64'hDEAD_BEEF);
    push_exp(M_DMA, 1'b0, 64'h0123_4567_89AB_CDEF);
    wait_sb(2, 40, "lock_two");
    tick();
    m0_lock = 1'b0;
    wait_sb(0, 40, "lock_release");
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask
`endif

  initial begin
    n_pass = 0; n_total = 0; n_strobes = 0; n_bad_strobes = 0; last_wr_addr = '0;
    reset = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0; m0_size = '0; m1_size = '0;
`ifdef MEM_ARB_LOCK_EN
    m0_lock = 1'b0; m1_lock = 1'b0;
`endif
    test_reset();
    test_single_read();
    test_gpio_write();
    test_alternation();
    test_reset_mid_access();
    test_req_drop();
`ifdef MEM_ARB_LOCK_EN
    test_lock();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
